// File: rtl/sprite_sched_pkg.sv
// Shared geometry, flash timing and types for the beat-sequencer sprite column.
package sprite_sched_pkg;

    localparam int SPRITE_W     = 35;
    localparam int SPRITE_H     = 35;
    localparam int X_BASE       = 0;
    localparam int Y_BASE       = 86;
    localparam int Y_PITCH      = 56;
    localparam int FLASH_FRAMES = 8;

    typedef logic [1:0] sprite_idx_t;
    typedef logic [7:0] flash_cnt_t;

    // Top row of band idx, widened so later offset arithmetic cannot wrap.
    function automatic logic [19:0] band_top(input int base, input int pitch, input int idx);
        return 20'(base + idx * pitch);
    endfunction

endpackage

// File: rtl/flash_timer.sv
// One sprite's highlight timer: latches a beat hit and reloads its frame
// countdown only at frame start so the highlight never tears mid-frame.
module flash_timer #(
    parameter int FRAMES = 8
) (
    input  logic vga_clk,
    input  logic reset,
    input  logic hit,
    input  logic fs,
    output logic vis
);
    import sprite_sched_pkg::*;

    logic       pending_r;
    logic       pending_nxt_s;
    flash_cnt_t count_r;
    flash_cnt_t count_nxt_s;

    // Next-state: a hit on the fs cycle itself waits for the following fs.
    always_comb begin
        count_nxt_s   = count_r;
        pending_nxt_s = hit | (pending_r & ~fs);
        if (fs) begin
            if (pending_r) begin
                count_nxt_s = flash_cnt_t'(FRAMES);
            end else if (count_r != 8'd0) begin
                count_nxt_s = count_r - 8'd1;
            end else begin
                count_nxt_s = 8'd0;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State and registered visibility flag.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b0;
            count_r   <= 8'd0;
            vis       <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            count_r   <= count_nxt_s;
            vis       <= (count_nxt_s != 8'd0);
        end
    end

endmodule

// File: rtl/sprite_layer_sched.sv
// Sprite column scheduler: picks the active band for the current pixel, drives
// the shared sprite ROM, and delivers a two-stage pixel tag aligned to ROM data.
module sprite_layer_sched #(
    parameter int NUM_SPRITES  = 4,
    parameter int SPRITE_W     = sprite_sched_pkg::SPRITE_W,
    parameter int SPRITE_H     = sprite_sched_pkg::SPRITE_H,
    parameter int X_BASE       = sprite_sched_pkg::X_BASE,
    parameter int Y_BASE       = sprite_sched_pkg::Y_BASE,
    parameter int Y_PITCH      = sprite_sched_pkg::Y_PITCH,
    parameter int ADDR_W       = 11,
    parameter int FLASH_FRAMES = sprite_sched_pkg::FLASH_FRAMES
) (
    input  logic                           vga_clk,
    input  logic                           reset,
    input  logic [9:0]                     DrawX,
    input  logic [9:0]                     DrawY,
    input  logic                           blank,
    input  logic [NUM_SPRITES-1:0]         hit,
    output logic [ADDR_W-1:0]              rom_address,
    output logic [$clog2(NUM_SPRITES)-1:0] rom_sel,
    output logic                           rom_valid,
    output logic                           pix_valid,
    output logic [$clog2(NUM_SPRITES)-1:0] pix_sel,
    output logic                           pix_flash,
    output logic [NUM_SPRITES-1:0]         flash_vis
);
    import sprite_sched_pkg::*;

    localparam int          SEL_W = $clog2(NUM_SPRITES);
    localparam logic [19:0] X_LO  = 20'(X_BASE);
    localparam logic [19:0] X_HI  = 20'(X_BASE + SPRITE_W);

    logic [19:0]            x_ext_s;
    logic [19:0]            y_ext_s;
    logic                   band_valid_s;
    logic [SEL_W-1:0]       sel_s;
    logic [ADDR_W-1:0]      addr_s;
    logic                   fs_s;
    logic [NUM_SPRITES-1:0] vis_s;

    // Band decode; scanning from the top index down lets the lowest index win.
    always_comb begin
        x_ext_s      = {10'd0, DrawX};
        y_ext_s      = {10'd0, DrawY};
        band_valid_s = 1'b0;
        sel_s        = '0;
        addr_s       = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            logic [19:0] y_top;
            logic        match;
            y_top = band_top(Y_BASE, Y_PITCH, i);
            match = blank && (x_ext_s >= X_LO) && (x_ext_s < X_HI) &&
                    (y_ext_s >= y_top) && (y_ext_s < y_top + 20'(SPRITE_H));
            band_valid_s = band_valid_s | match;
            sel_s        = match ? SEL_W'(i) : sel_s;
            addr_s       = match ? ADDR_W'((x_ext_s - X_LO) + (y_ext_s - y_top) * 20'(SPRITE_W))
                                 : addr_s;
        end
    end

    assign fs_s = (DrawX == 10'd0) && (DrawY == 10'd0);

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_timer
        flash_timer #(
            .FRAMES (FLASH_FRAMES)
        ) u_flash_timer (
            .vga_clk (vga_clk),
            .reset   (reset),
            .hit     (hit[g]),
            .fs      (fs_s),
            .vis     (vis_s[g])
        );
    end

    assign flash_vis = vis_s;

    // Stage 1 feeds the ROM; stage 2 lines up with the ROM's negedge-sampled data.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address <= '0;
            rom_sel     <= '0;
            rom_valid   <= 1'b0;
            pix_valid   <= 1'b0;
            pix_sel     <= '0;
            pix_flash   <= 1'b0;
        end else begin
            rom_address <= addr_s;
            rom_sel     <= sel_s;
            rom_valid   <= band_valid_s;
            pix_valid   <= rom_valid;
            pix_sel     <= rom_sel;
            pix_flash   <= vis_s[rom_sel] & rom_valid;
        end
    end

endmodule

// File: tb/tb_sprite_layer_sched.sv
// Bench for sprite_layer_sched: table vectors for band decode plus frame
// sequences for the flash timers, checked through an output scoreboard.
module tb_sprite_layer_sched;
    import sprite_sched_pkg::*;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic [3:0]  hit;
    logic [10:0] rom_address;
    logic [1:0]  rom_sel;
    logic        rom_valid;
    logic        pix_valid;
    logic [1:0]  pix_sel;
    logic        pix_flash;
    logic [3:0]  flash_vis;

    sprite_layer_sched dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .hit         (hit),
        .rom_address (rom_address),
        .rom_sel     (rom_sel),
        .rom_valid   (rom_valid),
        .pix_valid   (pix_valid),
        .pix_sel     (pix_sel),
        .pix_flash   (pix_flash),
        .flash_vis   (flash_vis)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [10:0] addr;
        logic        fl;
    } exp_t;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b;
        logic        v;
        logic [1:0]  sel;
        logic [10:0] addr;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    exp_t rom_q[$];
    exp_t pix_q[$];
    logic m_pend[4];
    int   m_cnt[4];
    logic [3:0] m_vis;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        m_vis = 4'd0;
        rom_q.delete();
        pix_q.delete();
    endtask

    task automatic model_band(input logic [9:0] x, input logic [9:0] y, input logic b,
                              output logic v, output logic [1:0] s, output logic [10:0] a);
        v = 1'b0;
        s = 2'd0;
        a = 11'd0;
        for (int i = 3; i >= 0; i--) begin
            int yi;
            yi = 86 + 56 * i;
            if (b && int'(x) < 35 && int'(y) >= yi && int'(y) < yi + 35) begin
                v = 1'b1;
                s = i[1:0];
                a = 11'(int'(x) + (int'(y) - yi) * 35);
            end
        end
    endtask

    // Drive one pixel, update the reference timers, then check outputs after the edge.
    task automatic step_exp(input logic [9:0] x, input logic [9:0] y, input logic b,
                            input logic [3:0] h, input logic ev, input logic [1:0] esel,
                            input logic [10:0] eaddr);
        exp_t e;
        logic fs;
        @(negedge vga_clk);
        DrawX = x;
        DrawY = y;
        blank = b;
        hit   = h;
        fs    = (x == 10'd0) && (y == 10'd0);
        for (int i = 0; i < 4; i++) begin
            if (fs) begin
                if (m_pend[i]) begin
                    m_cnt[i]  = 8;
                    m_pend[i] = 1'b0;
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            if (h[i]) m_pend[i] = 1'b1;
            m_vis[i] = (m_cnt[i] != 0);
        end
        e.v    = ev;
        e.sel  = esel;
        e.addr = eaddr;
        e.fl   = m_vis[esel] & ev;
        rom_q.push_back(e);
        pix_q.push_back(e);
        @(posedge vga_clk);
        #1;
        e = rom_q.pop_front();
        chk("rom_valid",   int'(rom_valid),   int'(e.v));
        chk("rom_sel",     int'(rom_sel),     int'(e.sel));
        chk("rom_address", int'(rom_address), int'(e.addr));
        chk("flash_vis",   int'(flash_vis),   int'(m_vis));
        if (pix_q.size() == 2) begin
            e = pix_q.pop_front();
            chk("pix_valid", int'(pix_valid), int'(e.v));
            chk("pix_sel",   int'(pix_sel),   int'(e.sel));
            chk("pix_flash", int'(pix_flash), int'(e.fl));
        end
    endtask

    task automatic step_m(input logic [9:0] x, input logic [9:0] y, input logic b,
                          input logic [3:0] h);
        logic        v;
        logic [1:0]  s;
        logic [10:0] a;
        model_band(x, y, b, v, s, a);
        step_exp(x, y, b, h, v, s, a);
    endtask

    // Short raster: frame start, one pixel in each band, a few off-band pixels.
    task automatic frame(input logic [3:0] hfs, input logic [3:0] hmid,
                         output logic [3:0] vis_seen);
        step_m(10'd0, 10'd0, 1'b1, hfs);
        vis_seen = flash_vis;
        step_m(10'd2,  10'd88,  1'b1, 4'd0);
        step_m(10'd2,  10'd144, 1'b1, 4'd0);
        step_m(10'd2,  10'd200, 1'b1, hmid);
        step_m(10'd2,  10'd256, 1'b1, 4'd0);
        step_m(10'd60, 10'd300, 1'b1, 4'd0);
        step_m(10'd2,  10'd140, 1'b1, 4'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rom_valid"},   int'(rom_valid),   0);
        chk({tag, "_rom_address"}, int'(rom_address), 0);
        chk({tag, "_rom_sel"},     int'(rom_sel),     0);
        chk({tag, "_pix_valid"},   int'(pix_valid),   0);
        chk({tag, "_pix_sel"},     int'(pix_sel),     0);
        chk({tag, "_pix_flash"},   int'(pix_flash),   0);
        chk({tag, "_flash_vis"},   int'(flash_vis),   0);
    endtask

    initial begin
        logic [3:0] v;
        tbl[0]  = '{10'd5,   10'd201, 1'b1, 1'b1, 2'd2, 11'd110};
        tbl[1]  = '{10'd5,   10'd201, 1'b0, 1'b0, 2'd0, 11'd0};
        tbl[2]  = '{10'd35,  10'd201, 1'b1, 1'b0, 2'd0, 11'd0};
        tbl[3]  = '{10'd34,  10'd201, 1'b1, 1'b1, 2'd2, 11'd139};
        tbl[4]  = '{10'd0,   10'd86,  1'b1, 1'b1, 2'd0, 11'd0};
        tbl[5]  = '{10'd34,  10'd120, 1'b1, 1'b1, 2'd0, 11'd1224};
        tbl[6]  = '{10'd0,   10'd121, 1'b1, 1'b0, 2'd0, 11'd0};
        tbl[7]  = '{10'd0,   10'd142, 1'b1, 1'b1, 2'd1, 11'd0};
        tbl[8]  = '{10'd10,  10'd254, 1'b1, 1'b1, 2'd3, 11'd10};
        tbl[9]  = '{10'd0,   10'd288, 1'b1, 1'b1, 2'd3, 11'd1190};
        tbl[10] = '{10'd0,   10'd289, 1'b1, 1'b0, 2'd0, 11'd0};
        tbl[11] = '{10'd0,   10'd85,  1'b1, 1'b0, 2'd0, 11'd0};

        reset = 1'b1;
        DrawX = 10'd100;
        DrawY = 10'd5;
        blank = 1'b0;
        hit   = 4'd0;
        model_clear();
        repeat (3) @(posedge vga_clk);
        #1;
        check_zero("reset");
        @(negedge vga_clk);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) begin
            step_exp(tbl[k].x, tbl[k].y, tbl[k].b, 4'd0, tbl[k].v, tbl[k].sel, tbl[k].addr);
        end

        // hit[1] mid-frame: dark until next frame start, then exactly eight frames.
        frame(4'd0, 4'b0010, v);
        chk("hit1_before_fs", int'(v[1]), 0);
        for (int f = 0; f < 10; f++) begin
            frame(4'd0, 4'd0, v);
            chk("hit1_frame", int'(v[1]), (f < 8) ? 1 : 0);
        end

        // Retrigger sprite 0 during its fifth highlighted frame.
        frame(4'd0, 4'b0001, v);
        for (int f = 1; f <= 15; f++) begin
            frame(4'd0, (f == 5) ? 4'b0001 : 4'd0, v);
            chk("retrig0_frame", int'(v[0]), (f <= 13) ? 1 : 0);
        end

        // A hit on the frame-start cycle waits for the following frame start.
        frame(4'b1000, 4'd0, v);
        chk("fs_hit3_same", int'(v[3]), 0);
        frame(4'd0, 4'd0, v);
        chk("fs_hit3_next", int'(v[3]), 1);

        // Reset mid-frame with sprites 0 and 2 flashing and sprite 1 pending.
        frame(4'd0, 4'b0101, v);
        frame(4'd0, 4'd0, v);
        chk("pre_reset_vis02", int'(v & 4'b0101), 5);
        step_m(10'd2, 10'd150, 1'b1, 4'b0010);
        step_m(10'd3, 10'd150, 1'b1, 4'd0);
        @(negedge vga_clk);
        reset = 1'b1;
        DrawX = 10'd100;
        DrawY = 10'd5;
        blank = 1'b0;
        hit   = 4'd0;
        #1;
        check_zero("midreset");
        model_clear();
        @(negedge vga_clk);
        reset = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame(4'd0, 4'd0, v);
            chk("post_reset_vis", int'(v), 0);
        end

        step_m(10'd100, 10'd5, 1'b0, 4'd0);
        step_m(10'd100, 10'd5, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
